// File: rtl/wta_argmin_tree_pkg.sv
// Shared types and helpers for the winner-take-all argmin reduction tree.
// Candidate fields are sized to the widest supported configuration and zero-extended.
package wta_argmin_tree_pkg;

  localparam int SUM_MAX_W  = 32;
  localparam int DISP_MAX_W = 16;

  localparam logic [SUM_MAX_W-1:0] SUM_ALL_ONES = '1;

  typedef struct packed {
    logic [SUM_MAX_W-1:0]  sum;
    logic [DISP_MAX_W-1:0] disp;
    logic                  tie;
  } cand_t;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } side_t;

  // All-ones value of a w-bit sum, right-aligned in the wide field.
  function automatic logic [SUM_MAX_W-1:0] sum_ones(input int w);
    return SUM_ALL_ONES >> (SUM_MAX_W - w);
  endfunction

  function automatic int num_stages(input int lanes);
    return $clog2(lanes);
  endfunction

endpackage

// File: rtl/wta_argmin_tree_cmp2.sv
// Pairwise unsigned compare: lower sum wins, equal sums keep operand a and flag a tie.
// Operand a must always be the lower-index (or earlier) candidate.
module wta_cmp2
  import wta_argmin_tree_pkg::*;
(
  input  cand_t a_i,
  input  cand_t b_i,
  output cand_t y_o
);

  always_comb begin
    // NOTE: y_o gets a complete default first, so no branch leaves it unassigned and no latch is inferred.
    y_o = a_i;
    if (b_i.sum < a_i.sum) begin
      y_o = b_i;
    end else if (b_i.sum == a_i.sum) begin
      y_o.tie = 1'b1;
    end
  end

endmodule

// File: rtl/wta_argmin_tree.sv
// Pipelined argmin over LANES window sums per beat, accumulated across a multi-beat
// sequence; one result pulse per sequence, log2(LANES)+1 cycles after the last beat.
module wta_argmin_tree
  import wta_argmin_tree_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int SUM_W  = 14,
  parameter int DISP_W = 6
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic                    in_first,
  input  logic                    in_last,
  input  logic [LANES*SUM_W-1:0]  in_ws,
  input  logic [DISP_W-1:0]       in_disp_base,
  output logic                    out_valid,
  output logic [DISP_W-1:0]       disparity,
  output logic [SUM_W-1:0]        window_sum,
  output logic                    tie
);

  localparam int STAGES = num_stages(LANES);
  localparam int NODES  = LANES - 1;

  logic [DISP_W-1:0] lane_disp [LANES];
  cand_t             leaf      [LANES];
  cand_t             node_d    [NODES];
  cand_t             node_q    [NODES];
  side_t             side_q    [STAGES];

  cand_t acc_q, acc_cmp, acc_d;
  cand_t out_q;
  logic  open_q;
  logic  fin_valid_q;
  logic  out_valid_q;
  logic  start_seq;
  side_t root_side;

  for (genvar i = 0; i < LANES; i++) begin : g_leaf
    assign lane_disp[i] = in_disp_base + DISP_W'(i);
    assign leaf[i] = '{sum:  SUM_MAX_W'(in_ws[i*SUM_W +: SUM_W]),
                       disp: DISP_MAX_W'(lane_disp[i]),
                       tie:  1'b0};
  end

  // Heap-ordered tree: node k has children 2k+1 and 2k+2; indices >= NODES are leaves,
  // laid out left to right so the left child always covers the lower lanes.
  for (genvar k = 0; k < NODES; k++) begin : g_node
    localparam int L = 2*k + 1;
    localparam int R = 2*k + 2;
    cand_t a, b;
    if (L >= NODES) begin : g_from_leaf
      assign a = leaf[L-NODES];
      assign b = leaf[R-NODES];
    end else begin : g_from_node
      assign a = node_q[L];
      assign b = node_q[R];
    end
    wta_cmp2 u_cmp (
      .a_i (a),
      .b_i (b),
      .y_o (node_d[k])
    );
  end

  // NOTE: datapath registers carry no reset; the valid sideband alone qualifies them.
  always_ff @(posedge clock) begin
    // NOTE: sequential state is always updated with non-blocking assignments.
    node_q <= node_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < STAGES; s++) side_q[s] <= '0;
    end else begin
      side_q[0] <= '{valid: in_valid, first: in_first, last: in_last};
      for (int s = 1; s < STAGES; s++) side_q[s] <= side_q[s-1];
    end
  end

  assign root_side = side_q[STAGES-1];

  // The stored best is the earlier operand, so equal sums keep the earlier disparity.
  wta_cmp2 u_acc_cmp (
    .a_i (acc_q),
    .b_i (node_q[0]),
    .y_o (acc_cmp)
  );

  always_comb begin
    start_seq = root_side.first | ~open_q;
    acc_d     = start_seq ? node_q[0] : acc_cmp;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      open_q      <= 1'b0;
      fin_valid_q <= 1'b0;
    end else begin
      fin_valid_q <= root_side.valid & root_side.last;
      if (root_side.valid) open_q <= ~root_side.last;
    end
  end

  always_ff @(posedge clock) begin
    if (root_side.valid) acc_q <= acc_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_q       <= '{sum: sum_ones(SUM_W), disp: '0, tie: 1'b0};
    end else begin
      out_valid_q <= fin_valid_q;
      if (fin_valid_q) out_q <= acc_q;
    end
  end

  assign out_valid  = out_valid_q;
  assign disparity  = out_q.disp[DISP_W-1:0];
  assign window_sum = out_q.sum[SUM_W-1:0];
  assign tie        = out_q.tie;

  // Upper bits of the wide fields are always zero here.
  logic unused_out_hi;
  assign unused_out_hi = ^{out_q.sum, out_q.disp};

endmodule

// File: tb/tb_wta_argmin_tree.sv
// Directed bench for wta_argmin_tree: a driver pushes expected results into a queue,
// and a monitor pops and compares on each out_valid pulse, including pulse timing.
module tb_wta_argmin_tree;

  localparam int LANES  = 4;
  localparam int SUM_W  = 14;
  localparam int DISP_W = 6;
  localparam int LAT    = 3;

  logic                   clock = 1'b0;
  logic                   reset = 1'b1;
  logic                   in_valid = 1'b0;
  logic                   in_first = 1'b0;
  logic                   in_last  = 1'b0;
  logic [LANES*SUM_W-1:0] in_ws    = '0;
  logic [DISP_W-1:0]      in_disp_base = '0;
  logic                   out_valid;
  logic [DISP_W-1:0]      disparity;
  logic [SUM_W-1:0]       window_sum;
  logic                   tie;

  typedef struct {
    logic [DISP_W-1:0] disp;
    logic [SUM_W-1:0]  sum;
    logic              tie;
    int                cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_pulses = 0;
  int   n_expected = 0;

  wta_argmin_tree #(.LANES(LANES), .SUM_W(SUM_W), .DISP_W(DISP_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_first     (in_first),
    .in_last      (in_last),
    .in_ws        (in_ws),
    .in_disp_base (in_disp_base),
    .out_valid    (out_valid),
    .disparity    (disparity),
    .window_sum   (window_sum),
    .tie          (tie)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Drives one beat at the falling edge; the following rising edge accepts it.
  task automatic beat(input logic v, input logic f, input logic l,
                      input int w0, input int w1, input int w2, input int w3,
                      input int base, input logic exp_en,
                      input int e_disp, input int e_sum, input logic e_tie);
    exp_t e;
    @(negedge clock);
    in_valid     = v;
    in_first     = f;
    in_last      = l;
    in_ws        = {SUM_W'(w3), SUM_W'(w2), SUM_W'(w1), SUM_W'(w0)};
    in_disp_base = DISP_W'(base);
    if (exp_en) begin
      e.disp = DISP_W'(e_disp);
      e.sum  = SUM_W'(e_sum);
      e.tie  = e_tie;
      e.cyc  = cyc + 1 + LAT;
      exp_q.push_back(e);
      n_expected++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      in_valid = 1'b0;
      in_first = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  always @(negedge clock) begin
    if (out_valid) begin
      n_pulses++;
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_cycle", 32'(cyc), 32'(e.cyc));
        check("disparity", 32'(disparity), 32'(e.disp));
        check("window_sum", 32'(window_sum), 32'(e.sum));
        check("tie", 32'(tie), 32'(e.tie));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clock);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_disparity", 32'(disparity), 32'd0);
    check("reset_window_sum", 32'(window_sum), 32'h3FFF);
    check("reset_tie", 32'(tie), 32'd0);
    reset = 1'b0;
    idle(2);

    // Single beat: min 12 on lane 1 -> disparity 9.
    beat(1, 1, 1, 40, 12, 30, 50, 8, 1, 9, 12, 0);
    idle(6);
    // Tie between lanes 0 and 1: lower lane wins.
    beat(1, 1, 1, 7, 7, 9, 9, 0, 1, 0, 7, 1);
    idle(6);
    // Three-beat sequence: 20@2, 5@6, 5@9 -> earlier 5 kept, tie set.
    beat(1, 1, 0, 30, 25, 20, 40, 0, 0, 0, 0, 0);
    beat(1, 0, 0, 9, 8, 5, 6, 4, 0, 0, 0, 0);
    beat(1, 0, 1, 7, 5, 8, 10, 8, 1, 6, 5, 1);
    idle(6);
    // Back-to-back singles with an invalid beat (first/last set) in slot 2.
    beat(1, 1, 1, 1, 2, 3, 4, 10, 1, 10, 1, 0);
    beat(0, 1, 1, 0, 0, 0, 0, 20, 0, 0, 0, 0);
    beat(1, 1, 1, 100, 90, 80, 70, 0, 1, 3, 70, 0);
    beat(1, 1, 1, 5, 3, 3, 9, 16, 1, 17, 3, 1);
    idle(8);

    // A complete beat still in the pipeline plus an open sequence, then reset.
    beat(1, 1, 1, 2, 2, 2, 2, 0, 0, 0, 0, 0);
    beat(1, 1, 0, 10, 10, 10, 10, 0, 0, 0, 0, 0);
    @(negedge clock);
    reset    = 1'b1;
    in_valid = 1'b1;
    in_first = 1'b1;
    in_last  = 1'b1;
    @(negedge clock);
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_disparity", 32'(disparity), 32'd0);
    check("rst_mid_window_sum", 32'(window_sum), 32'h3FFF);
    check("rst_mid_tie", 32'(tie), 32'd0);
    reset    = 1'b0;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
    beat(1, 1, 1, 3, 1, 4, 1, 5, 1, 6, 1, 1);
    idle(8);

    // Restart: first sequence discarded; base 62 wraps lane 3 to disparity 1.
    beat(1, 1, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0);
    beat(1, 1, 0, 50, 40, 60, 45, 62, 0, 0, 0, 0);
    beat(1, 0, 1, 44, 55, 41, 30, 62, 1, 1, 30, 0);
    idle(6);
    // No open sequence: a beat without first starts one implicitly.
    beat(1, 0, 1, 8, 6, 7, 9, 1, 1, 2, 6, 0);
    idle(12);

    check("pending_expectations", 32'(exp_q.size()), 32'd0);
    check("pulse_count", 32'(n_pulses), 32'(n_expected));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
